dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port access controller sitting between the single-port data RAM (`dram`) and its two requesters: the CPU load/store unit and the debug/program-loader port. It arbitrates between them round-robin and validates addresses. It performs byte/halfword stores as read-modify-write sequences on the word-wide RAM. It returns sign- or zero-extended sub-word load data. It owns every `dram` control signal; nothing else drives `dram` directly.

## Interface
Parameters:
- `ADDR_BASE`, 32'h1001_0000, byte address of RAM word 0
- `DEPTH_WORDS`, 2048, RAM depth; valid byte range is `ADDR_BASE` .. `ADDR_BASE + 4*DEPTH_WORDS - 1`

Ports:
- Clocking: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `cpu_req`  in  1  CPU request; held with all `cpu_*` fields stable until `cpu_ready`
- `cpu_we`  in  1  1 = store, 0 = load
- `cpu_size`  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- `cpu_sign`  in  1  loads: 1 = sign-extend, 0 = zero-extend
- `cpu_addr`  in  32  byte address
- `cpu_wdata`  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- `cpu_ready`  out  1  one-cycle completion pulse
- `cpu_rdata`  out  32  load result, valid while `cpu_ready`=1
- `cpu_err`  out  1  with `cpu_ready`: access rejected, no RAM write
- `dbg_req`, `dbg_we`, `dbg_addr[31:0]`, `dbg_wdata[31:0]`  in  debug port, word-only, same hold rule as CPU
- `dbg_ready`, `dbg_rdata[31:0]`, `dbg_err`  out  as CPU equivalents
- `mem_ena`  out  1  `dram` read enable
- `mem_wena`  out  1  `dram` write enable (written on rising edge)
- `mem_addr`  out  32  `dram` byte address, always word-aligned
- `mem_wdata`  out  32  `dram` write data
- `mem_rdata`  in  32  `dram` combinational read data

## Operation
- FSM states: IDLE, RD, WR, RMW_RD, RMW_WR, ERR.
- In IDLE, the requesters are sampled and a grant is made.
  - If only one requests, it is granted.
  - If both request, grant goes to the port not served last (`last_grant` register; reset value = CPU, so the debug port wins the first tie).
- A port whose `*_ready` is high in the current cycle is ignored for arbitration in that cycle, so a held request cannot be re-issued.
- On grant, the request fields are latched into internal registers.
- The next state is chosen from the latched request:
  - ERR if the address is out of range, misaligned (half with `addr[0]`=1, word with `addr[1:0]`≠0), or `cpu_size`=11. Debug requests are treated as size=word.
  - RD for any load.
  - WR for a word store.
  - RMW_RD for a byte or half store.
- State actions:
  - RD: `mem_ena`=1. Latch the extracted, extended data into the port's rdata register. Set ready, go to IDLE.
  - WR: `mem_wena`=1, `mem_wdata`=store data. Set ready, go to IDLE.
  - RMW_RD: `mem_ena`=1. Latch `mem_rdata` into the merge buffer, go to RMW_WR.
  - RMW_WR: `mem_wena`=1, `mem_wdata`=buffer with the selected lane(s) replaced. Set ready, go to IDLE.
  - ERR: no RAM enable. Set ready and err, rdata=0, go to IDLE.
- Lane selection is little-endian:
  - Byte k = bits [8k+7:8k], with k = `addr[1:0]`.
  - Half h = bits [16h+15:16h], with h = `addr[1]`.
- `mem_addr` = {`addr[31:2]`, 2'b00} during RD/WR/RMW_*, 0 otherwise.
- `mem_ena` and `mem_wena` are never high simultaneously and are 0 in IDLE and ERR.
- `*_ready` and `*_err` are registered, high exactly one cycle, and only for the granted port.
- `*_rdata` holds its last value until the next completed load on that port.

## Timing
- Reset (async, `rst_n`=0) sets:
  - state = IDLE, `last_grant` = CPU
  - all ready/err/mem enables = 0
  - `mem_addr` = `mem_wdata` = 0, `cpu_rdata` = `dbg_rdata` = 0
- Reset asserted mid-operation aborts it. No write occurs unless `mem_wena` was already high at a preceding edge. After release the aborted requester sees no ready; it must keep requesting and is served from IDLE.
- Latency counts from the edge sampling `req` in IDLE (cycle 0) to `ready` high:
  - load, word store, error: `ready` in cycle 2
  - sub-word store: `ready` in cycle 3
- Throughput:
  - A requester may present a new request in its ready cycle; it is sampled in the following cycle.
  - Under continuous contention, CPU and debug alternate.
- Simultaneous arrival, both idle: the tie-break above applies; the losing request stays pending with no timeout.

## Test plan
- Word store/load: CPU stores 0xDEADBEEF to 0x10010004, then loads it → `mem_wena` pulse at word 0x10010004; load returns `cpu_rdata`=0xDEADBEEF, `cpu_err`=0, ready in cycle 2.
- Byte RMW: word 0x10010000 = 0x11223344; CPU sb 0xAA to 0x10010002 → RMW_RD then RMW_WR, RAM = 0x11AA3344, ready in cycle 3. lb at the same address → 0xFFFFFFAA; lbu → 0x000000AA.
- Half RMW/extension: sh 0x8001 to 0x10010002 over 0x11223344 → 0x80013344. lh → 0xFFFF8001; lhu → 0x00008001.
- Errors, each giving `cpu_ready`=`cpu_err`=1, no `mem_ena`/`mem_wena`, RAM unchanged:
  - word load from 0x10010001 (misaligned)
  - store to 0x10012000 (out of range)
  - `cpu_size`=11
- Arbitration: both ports request continuously from reset → grants alternate dbg, cpu, dbg, …; no port gets two consecutive grants while the other waits.
- Reset mid-RMW: assert `rst_n`=0 during RMW_RD → all outputs 0 immediately, RAM word unchanged. After release the request completes normally.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Round-robin access controller between the CPU and debug ports and the single-port data RAM.
// Validates addresses, performs sub-word stores as read-modify-write and extends sub-word loads.
module dmem_arbiter #(
   parameter logic [31:0] ADDR_BASE   = 32'h1001_0000,
   parameter int          DEPTH_WORDS = 2048
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [1:0]  cpu_size,
   input  logic        cpu_sign,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic        cpu_ready,
   output logic [31:0] cpu_rdata,
   output logic        cpu_err,
   input  logic        dbg_req,
   input  logic        dbg_we,
   input  logic [31:0] dbg_addr,
   input  logic [31:0] dbg_wdata,
   output logic        dbg_ready,
   output logic [31:0] dbg_rdata,
   output logic        dbg_err,
   output logic        mem_ena,
   output logic        mem_wena,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [2:0] {IDLE, RD, WR, RMW_RD, RMW_WR, ERR} state_t;

   localparam logic [31:0] SPAN = 32'(4 * DEPTH_WORDS);

   state_t      state_reg, state_next;
   logic        last_grant_reg;            // 0 = CPU, 1 = debug
   logic        grant_dbg_reg;
   logic        we_reg, sign_reg;
   logic [1:0]  size_reg;
   logic [31:0] addr_reg, wdata_reg, buf_reg;
   logic        cpu_ready_reg, cpu_err_reg, dbg_ready_reg, dbg_err_reg;
   logic [31:0] cpu_rdata_reg, dbg_rdata_reg;

   logic        cpu_cand, dbg_cand, pick_dbg, grant_valid;
   logic        req_we, req_sign, req_bad;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata, req_offset;
   state_t      req_state;
   logic [31:0] merged, load_data;
   logic [7:0]  byte_v;
   logic [15:0] half_v;

   // A port completing this cycle is masked so its held request is not served twice.
   assign cpu_cand    = cpu_req && !cpu_ready_reg;
   assign dbg_cand    = dbg_req && !dbg_ready_reg;
   assign pick_dbg    = dbg_cand && (!cpu_cand || !last_grant_reg);
   assign grant_valid = cpu_cand || dbg_cand;

   always_comb begin
      req_we    = pick_dbg ? dbg_we    : cpu_we;
      req_size  = pick_dbg ? 2'b10     : cpu_size;
      req_sign  = pick_dbg ? 1'b0      : cpu_sign;
      req_addr  = pick_dbg ? dbg_addr  : cpu_addr;
      req_wdata = pick_dbg ? dbg_wdata : cpu_wdata;
      req_offset = req_addr - ADDR_BASE;
      req_bad   = (req_addr < ADDR_BASE) || (req_offset >= SPAN) || (req_size == 2'b11) ||
                  ((req_size == 2'b01) && req_addr[0]) ||
                  ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
      if (req_bad)
         req_state = ERR;
      else if (!req_we)
         req_state = RD;
      else if (req_size == 2'b10)
         req_state = WR;
      else
         req_state = RMW_RD;
   end

   always_comb begin
      merged = buf_reg;
      if (size_reg == 2'b00)
         merged[{addr_reg[1:0], 3'b000} +: 8] = wdata_reg[7:0];
      else
         merged[{addr_reg[1], 4'b0000} +: 16] = wdata_reg[15:0];
   end

   always_comb begin
      byte_v = mem_rdata[{addr_reg[1:0], 3'b000} +: 8];
      half_v = mem_rdata[{addr_reg[1], 4'b0000} +: 16];
      case (size_reg)
         2'b00:   load_data = {{24{sign_reg & byte_v[7]}}, byte_v};
         2'b01:   load_data = {{16{sign_reg & half_v[15]}}, half_v};
         default: load_data = mem_rdata;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      mem_ena    = 1'b0;
      mem_wena   = 1'b0;
      mem_addr   = 32'h0;
      mem_wdata  = 32'h0;
      case (state_reg)
         IDLE:   if (grant_valid) state_next = req_state;
         RD: begin
            mem_ena    = 1'b1;
            mem_addr   = {addr_reg[31:2], 2'b00};
            state_next = IDLE;
         end
         WR: begin
            mem_wena   = 1'b1;
            mem_addr   = {addr_reg[31:2], 2'b00};
            mem_wdata  = wdata_reg;
            state_next = IDLE;
         end
         RMW_RD: begin
            mem_ena    = 1'b1;
            mem_addr   = {addr_reg[31:2], 2'b00};
            state_next = RMW_WR;
         end
         RMW_WR: begin
            mem_wena   = 1'b1;
            mem_addr   = {addr_reg[31:2], 2'b00};
            mem_wdata  = merged;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant_reg <= 1'b0;
         grant_dbg_reg  <= 1'b0;
         we_reg         <= 1'b0;
         sign_reg       <= 1'b0;
         size_reg       <= 2'b00;
         addr_reg       <= 32'h0;
         wdata_reg      <= 32'h0;
         buf_reg        <= 32'h0;
         cpu_ready_reg  <= 1'b0;
         cpu_err_reg    <= 1'b0;
         dbg_ready_reg  <= 1'b0;
         dbg_err_reg    <= 1'b0;
         cpu_rdata_reg  <= 32'h0;
         dbg_rdata_reg  <= 32'h0;
      end else begin
         cpu_ready_reg <= 1'b0;
         cpu_err_reg   <= 1'b0;
         dbg_ready_reg <= 1'b0;
         dbg_err_reg   <= 1'b0;
         if (state_reg == IDLE && grant_valid) begin
            grant_dbg_reg  <= pick_dbg;
            last_grant_reg <= pick_dbg;
            we_reg         <= req_we;
            size_reg       <= req_size;
            sign_reg       <= req_sign;
            addr_reg       <= req_addr;
            wdata_reg      <= req_wdata;
         end
         if (state_reg == RMW_RD)
            buf_reg <= mem_rdata;
         if (state_reg == RD || state_reg == WR || state_reg == RMW_WR || state_reg == ERR) begin
            if (grant_dbg_reg) dbg_ready_reg <= 1'b1;
            else               cpu_ready_reg <= 1'b1;
         end
         if (state_reg == RD) begin
            if (grant_dbg_reg) dbg_rdata_reg <= load_data;
            else               cpu_rdata_reg <= load_data;
         end
         if (state_reg == ERR) begin
            if (grant_dbg_reg) begin
               dbg_err_reg   <= 1'b1;
               dbg_rdata_reg <= 32'h0;
            end else begin
               cpu_err_reg   <= 1'b1;
               cpu_rdata_reg <= 32'h0;
            end
         end
      end
   end

   assign cpu_ready = cpu_ready_reg;
   assign cpu_err   = cpu_err_reg;
   assign cpu_rdata = cpu_rdata_reg;
   assign dbg_ready = dbg_ready_reg;
   assign dbg_err   = dbg_err_reg;
   assign dbg_rdata = dbg_rdata_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: bench-owned RAM, arithmetic reference model of the word array,
// directed plan items followed by randomized CPU/debug traffic and a contention run.
module tb_dmem_arbiter;

   localparam logic [31:0] BASE  = 32'h1001_0000;
   localparam int          DEPTH = 2048;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cpu_req = 1'b0, cpu_we = 1'b0, cpu_sign = 1'b0;
   logic [1:0]  cpu_size = 2'b10;
   logic [31:0] cpu_addr = 32'h0, cpu_wdata = 32'h0;
   logic        cpu_ready, cpu_err;
   logic [31:0] cpu_rdata;
   logic        dbg_req = 1'b0, dbg_we = 1'b0;
   logic [31:0] dbg_addr = 32'h0, dbg_wdata = 32'h0;
   logic        dbg_ready, dbg_err;
   logic [31:0] dbg_rdata;
   logic        mem_ena, mem_wena;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   logic [31:0] ram     [0:DEPTH-1];
   logic [31:0] ref_mem [0:DEPTH-1];
   logic [31:0] last_rd [0:1];
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(.ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size), .cpu_sign(cpu_sign),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready),
      .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_ready(dbg_ready), .dbg_rdata(dbg_rdata), .dbg_err(dbg_err),
      .mem_ena(mem_ena), .mem_wena(mem_wena), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   // The dram itself: combinational read, write on rising edge.
   logic        ram_hit;
   logic [10:0] ram_idx;
   always_comb begin
      ram_hit   = (mem_addr >= BASE) && ((mem_addr - BASE) < 32'(4 * DEPTH));
      ram_idx   = 11'((mem_addr - BASE) >> 2);
      mem_rdata = ram_hit ? ram[ram_idx] : 32'h0;
   end
   always @(posedge clk) if (mem_wena && ram_hit) ram[ram_idx] <= mem_wdata;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit legal(input logic [31:0] a, input logic [1:0] sz);
      logic [63:0] hi;
      hi = {32'h0, BASE} + 64'(4 * DEPTH);
      if (sz == 2'd3) return 1'b0;
      if (a < BASE || {32'h0, a} >= hi) return 1'b0;
      if ((a % (32'd1 << sz)) != 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic do_reset();
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      last_rd[0] = 32'h0;
      last_rd[1] = 32'h0;
   endtask

   // One access on one port (0 = CPU, 1 = debug); expectations from the model.
   task automatic access(input bit port, input logic we, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
      logic [1:0]  esz;
      bit          ok, rdy, saw_ena, saw_wena, both, other, bad_addr;
      int          exp_lat, n, sh, width;
      logic [10:0] idx;
      logic [63:0] lmask, v;
      esz = port ? 2'd2 : sz;
      ok  = legal(a, esz);
      idx = 11'((a - BASE) >> 2);
      sh  = int'(a[1:0]) * 8;
      exp_lat = 2;
      if (!ok) begin
         last_rd[port] = 32'h0;
      end else begin
         width = 8 << esz;
         lmask = (64'd1 << width) - 64'd1;
         if (we) begin
            v = ({32'h0, ref_mem[idx]} & ~(lmask << sh)) | (({32'h0, wd} & lmask) << sh);
            ref_mem[idx] = v[31:0];
            if (esz != 2'd2) exp_lat = 3;
         end else begin
            v = ({32'h0, ref_mem[idx]} >> sh) & lmask;
            if (sg && width < 32 && v[width-1]) v = v | ~lmask;
            last_rd[port] = v[31:0];
         end
      end
      if (port) begin
         dbg_req = 1'b1; dbg_we = we; dbg_addr = a; dbg_wdata = wd;
      end else begin
         cpu_req = 1'b1; cpu_we = we; cpu_size = sz; cpu_sign = sg; cpu_addr = a; cpu_wdata = wd;
      end
      n = 0; rdy = 1'b0; saw_ena = 1'b0; saw_wena = 1'b0; both = 1'b0; other = 1'b0; bad_addr = 1'b0;
      while (!rdy && n < 30) begin
         @(negedge clk);
         n++;
         if (mem_ena) saw_ena = 1'b1;
         if (mem_wena) saw_wena = 1'b1;
         if (mem_ena && mem_wena) both = 1'b1;
         if ((mem_ena || mem_wena) && mem_addr !== {a[31:2], 2'b00}) bad_addr = 1'b1;
         if (port ? cpu_ready : dbg_ready) other = 1'b1;
         rdy = port ? dbg_ready : cpu_ready;
      end
      $display("txn port=%s we=%0d size=%0d sign=%0d addr=%h wdata=%h -> ready@%0d err=%0d rdata=%h",
               port ? "dbg" : "cpu", we, esz, sg, a, wd, n,
               port ? dbg_err : cpu_err, port ? dbg_rdata : cpu_rdata);
      chk("latency", 32'(n), 32'(exp_lat));
      chk("err", {31'h0, port ? dbg_err : cpu_err}, {31'h0, !ok});
      chk("rdata", port ? dbg_rdata : cpu_rdata, last_rd[port]);
      chk("ena_wena_overlap", {31'h0, both}, 32'h0);
      chk("mem_addr", {31'h0, bad_addr}, 32'h0);
      chk("other_port_ready", {31'h0, other}, 32'h0);
      if (!ok)
         chk("err_no_ram_access", {30'h0, saw_ena, saw_wena}, 32'h0);
      else begin
         chk("wena_seen", {31'h0, saw_wena}, {31'h0, we});
         chk("ram_word", ram[idx], ref_mem[idx]);
      end
      cpu_req = 1'b0;
      dbg_req = 1'b0;
      @(negedge clk);
      chk("ready_one_cycle", {31'h0, port ? dbg_ready : cpu_ready}, 32'h0);
   endtask

   initial begin
      logic [31:0] a, ca, da;
      logic [1:0]  sz;
      logic [10:0] idx;
      int          n, g, cyc, both_cnt;
      int          seq [0:7];
      logic [31:0] wd;

      for (int i = 0; i < DEPTH; i++) begin
         ram[i]     = $urandom;
         ref_mem[i] = ram[i];
      end
      last_rd[0] = 32'h0;
      last_rd[1] = 32'h0;

      // Reset state
      #12;
      chk("rst_cpu_ready", {31'h0, cpu_ready}, 32'h0);
      chk("rst_mem_ena", {30'h0, mem_ena, mem_wena}, 32'h0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      chk("rst_rdata", cpu_rdata | dbg_rdata, 32'h0);
      do_reset();

      // Directed plan items
      access(0, 1, 2'd2, 0, 32'h1001_0004, 32'hDEAD_BEEF);
      access(0, 0, 2'd2, 0, 32'h1001_0004, 32'h0);
      chk("lw_const", cpu_rdata, 32'hDEAD_BEEF);
      access(0, 1, 2'd2, 0, 32'h1001_0000, 32'h1122_3344);
      access(0, 1, 2'd0, 0, 32'h1001_0002, 32'h0000_00AA);
      chk("sb_ram_const", ram[0], 32'h11AA_3344);
      access(0, 0, 2'd0, 1, 32'h1001_0002, 32'h0);
      chk("lb_const", cpu_rdata, 32'hFFFF_FFAA);
      access(0, 0, 2'd0, 0, 32'h1001_0002, 32'h0);
      chk("lbu_const", cpu_rdata, 32'h0000_00AA);
      access(0, 1, 2'd2, 0, 32'h1001_0000, 32'h1122_3344);
      access(0, 1, 2'd1, 0, 32'h1001_0002, 32'h0000_8001);
      chk("sh_ram_const", ram[0], 32'h8001_3344);
      access(0, 0, 2'd1, 1, 32'h1001_0002, 32'h0);
      chk("lh_const", cpu_rdata, 32'hFFFF_8001);
      access(0, 0, 2'd1, 0, 32'h1001_0002, 32'h0);
      chk("lhu_const", cpu_rdata, 32'h0000_8001);
      access(0, 0, 2'd2, 0, 32'h1001_0001, 32'h0);
      access(0, 1, 2'd2, 0, 32'h1001_2000, 32'h1234_5678);
      access(0, 1, 2'd3, 0, 32'h1001_0008, 32'h1234_5678);
      access(1, 1, 2'd2, 0, 32'h1001_1FFC, 32'hCAFE_F00D);
      access(1, 0, 2'd2, 0, 32'h1001_1FFC, 32'h0);
      access(1, 0, 2'd2, 0, 32'h1001_0006, 32'h0);
      access(0, 0, 2'd0, 1, 32'h1000_FFFF, 32'h0);

      // Randomized traffic on a small window plus occasional out-of-range addresses
      for (int t = 0; t < 80; t++) begin
         a = BASE + $urandom_range(0, 63);
         if ($urandom_range(0, 9) == 0) a = BASE + 32'(4 * DEPTH) + $urandom_range(0, 15);
         if ($urandom_range(0, 19) == 0) a = BASE - $urandom_range(1, 8);
         sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         access(($urandom_range(0, 3) == 0), 1'($urandom), sz, 1'($urandom), a, $urandom);
      end

      // Continuous contention from reset: grants alternate dbg, cpu, dbg, ...
      do_reset();
      @(negedge clk);
      ca = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
      da = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_size = 2'd2; cpu_sign = 1'b0; cpu_addr = ca;
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = da;
      g = 0; cyc = 0; both_cnt = 0;
      while (g < 8 && cyc < 80) begin
         @(negedge clk);
         cyc++;
         if (cpu_ready && dbg_ready) both_cnt++;
         if (cpu_ready && g < 8) begin
            chk("arb_cpu_rdata", cpu_rdata, ref_mem[11'((ca - BASE) >> 2)]);
            $display("txn arb grant=%0d port=cpu addr=%h rdata=%h", g, ca, cpu_rdata);
            seq[g] = 0; g++;
            ca = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
            cpu_addr = ca;
         end
         if (dbg_ready && g < 8) begin
            chk("arb_dbg_rdata", dbg_rdata, ref_mem[11'((da - BASE) >> 2)]);
            $display("txn arb grant=%0d port=dbg addr=%h rdata=%h", g, da, dbg_rdata);
            seq[g] = 1; g++;
            da = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
            dbg_addr = da;
         end
      end
      cpu_req = 1'b0;
      dbg_req = 1'b0;
      chk("arb_grant_count", 32'(g), 32'd8);
      chk("arb_both_ready", 32'(both_cnt), 32'h0);
      for (int i = 0; i < g; i++)
         chk("arb_order", 32'(seq[i]), (i % 2 == 0) ? 32'd1 : 32'd0);
      repeat (3) @(negedge clk);
      last_rd[0] = cpu_rdata;
      last_rd[1] = dbg_rdata;

      // Reset asserted during RMW_RD, request held across reset and then served
      a   = 32'h1001_0041;
      wd  = $urandom;
      idx = 11'((a - BASE) >> 2);
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_size = 2'd0; cpu_sign = 1'b0; cpu_addr = a; cpu_wdata = wd;
      @(negedge clk);
      chk("rmw_rd_ena", {31'h0, mem_ena}, 32'h1);
      rst_n = 1'b0;
      #1;
      chk("abort_mem_en", {30'h0, mem_ena, mem_wena}, 32'h0);
      chk("abort_mem_addr", mem_addr, 32'h0);
      chk("abort_mem_wdata", mem_wdata, 32'h0);
      chk("abort_ready", {30'h0, cpu_ready, cpu_err}, 32'h0);
      @(negedge clk);
      chk("abort_ram_word", ram[idx], ref_mem[idx]);
      rst_n = 1'b1;
      n = 0;
      while (!cpu_ready && n < 30) begin
         @(negedge clk);
         n++;
      end
      ref_mem[idx][15:8] = wd[7:0];
      $display("txn port=cpu sb after reset addr=%h wdata=%h -> ready@%0d", a, wd, n);
      chk("post_reset_latency", 32'(n), 32'd3);
      chk("post_reset_ram", ram[idx], ref_mem[idx]);
      chk("post_reset_err", {31'h0, cpu_err}, 32'h0);
      cpu_req = 1'b0;
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
